// File: rtl/victim_pkg.sv
// Shared sizing and helpers for the victim-cache tag store.
package victim_pkg;

  localparam int NUM_ENTRIES   = 8;
  localparam int IDX_W         = 3;
  localparam int DEFAULT_TAG_W = 8;

  function automatic logic [3:0] popcount8(input logic [NUM_ENTRIES-1:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sum = sum + {3'b000, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/prio_enc8_3.sv
// Lowest-set-bit priority encoder: index of the lowest set request bit plus an any-set flag.
module prio_enc8_3
  import victim_pkg::*;
(
  input  logic [NUM_ENTRIES-1:0] req,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  // Scanning downward lets the lowest set bit be written last and win.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/victim_tag_store.sv
// Eight-entry fully associative victim tag store with lowest-index hit select,
// lowest-free insert placement and round-robin replacement when full.
module victim_tag_store
  import victim_pkg::*;
#(
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             lookup_take,
  input  logic             insert_valid,
  input  logic [TAG_W-1:0] insert_tag,
  output logic             hit_valid,
  output logic             hit,
  output logic [IDX_W-1:0] hit_sel,
  output logic             evict_valid,
  output logic [TAG_W-1:0] evict_tag,
  output logic [3:0]       count,
  output logic             full
);

  logic [NUM_ENTRIES-1:0] valid;
  logic [TAG_W-1:0]       tags [NUM_ENTRIES];
  logic [IDX_W-1:0]       rr_ptr;

  logic [NUM_ENTRIES-1:0] match_vec;
  logic [NUM_ENTRIES-1:0] dup_vec;
  logic [IDX_W-1:0]       hit_idx;
  logic                   any_hit;
  logic [IDX_W-1:0]       free_idx;
  logic                   any_free;

  logic                   take_do;
  logic                   ins_do;
  logic                   ins_evict;
  logic [IDX_W-1:0]       ins_idx;
  logic [NUM_ENTRIES-1:0] valid_nxt;

  always_comb begin
    match_vec = '0;
    dup_vec   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match_vec[i] = valid[i] && (tags[i] == lookup_tag);
      dup_vec[i]   = valid[i] && (tags[i] == insert_tag);
    end
  end

  prio_enc8_3 u_hit_enc (
    .req (match_vec),
    .idx (hit_idx),
    .any (any_hit)
  );

  prio_enc8_3 u_free_enc (
    .req (~valid),
    .idx (free_idx),
    .any (any_free)
  );

  // All decisions use pre-edge state; an insert into the slot being taken wins.
  always_comb begin
    take_do   = lookup_valid && lookup_take && any_hit;
    ins_do    = insert_valid && !(|dup_vec);
    ins_evict = ins_do && !any_free;
    ins_idx   = any_free ? free_idx : rr_ptr;
    valid_nxt = valid;
    if (take_do) valid_nxt[hit_idx] = 1'b0;
    if (ins_do)  valid_nxt[ins_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= '0;
      rr_ptr      <= '0;
      hit_valid   <= 1'b0;
      hit         <= 1'b0;
      hit_sel     <= '0;
      evict_valid <= 1'b0;
      evict_tag   <= '0;
      count       <= 4'd0;
      full        <= 1'b0;
    end else begin
      valid       <= valid_nxt;
      count       <= popcount8(valid_nxt);
      full        <= &valid_nxt;
      hit_valid   <= lookup_valid;
      hit         <= lookup_valid && any_hit;
      evict_valid <= ins_evict;
      if (lookup_valid) begin
        hit_sel <= any_hit ? hit_idx : '0;
      end
      if (ins_evict) begin
        evict_tag <= tags[rr_ptr];
        rr_ptr    <= rr_ptr + 3'd1;
      end
    end
  end

  // Tag payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (ins_do) begin
      tags[ins_idx] <= insert_tag;
    end
  end

endmodule

// File: tb/tb_victim_tag_store.sv
// Directed checks of victim_tag_store: fill, hit/miss, round-robin eviction, take, reset.
module tb_victim_tag_store;

  logic       clk;
  logic       reset;
  logic       lookup_valid;
  logic [7:0] lookup_tag;
  logic       lookup_take;
  logic       insert_valid;
  logic [7:0] insert_tag;
  logic       hit_valid;
  logic       hit;
  logic [2:0] hit_sel;
  logic       evict_valid;
  logic [7:0] evict_tag;
  logic [3:0] count;
  logic       full;

  int tb_checks = 0;
  int tb_errors = 0;

  victim_tag_store #(.TAG_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_tag   (lookup_tag),
    .lookup_take  (lookup_take),
    .insert_valid (insert_valid),
    .insert_tag   (insert_tag),
    .hit_valid    (hit_valid),
    .hit          (hit),
    .hit_sel      (hit_sel),
    .evict_valid  (evict_valid),
    .evict_tag    (evict_tag),
    .count        (count),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tb_checks++;
    if (got !== exp) begin
      tb_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid = 1'b0;
    lookup_take  = 1'b0;
    insert_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [7:0] t, input logic take);
    lookup_valid = 1'b1;
    lookup_tag   = t;
    lookup_take  = take;
    insert_valid = 1'b0;
    step();
    idle();
  endtask

  task automatic do_insert(input logic [7:0] t);
    lookup_valid = 1'b0;
    insert_valid = 1'b1;
    insert_tag   = t;
    step();
    idle();
  endtask

  logic [7:0] exp_ev [9];

  initial begin
    exp_ev = '{8'h14, 8'h40, 8'h16, 8'h17, 8'h20, 8'h21, 8'h30, 8'h50, 8'h60};
    reset = 1'b1;
    idle();
    lookup_tag = 8'h00;
    insert_tag = 8'h00;
    step();
    step();
    check_val("rst_hit_valid", {31'd0, hit_valid}, 32'd0);
    check_val("rst_count", {28'd0, count}, 32'd0);
    check_val("rst_full", {31'd0, full}, 32'd0);
    check_val("rst_evict_tag", {24'd0, evict_tag}, 32'd0);
    reset = 1'b0;
    step();

    // fill 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      do_insert(8'h10 + 8'(i));
      check_val("fill_no_evict", {31'd0, evict_valid}, 32'd0);
      check_val("fill_count", {28'd0, count}, 32'(i + 1));
    end
    check_val("fill_full", {31'd0, full}, 32'd1);

    do_lookup(8'h13, 1'b0);
    check_val("lk13_hv", {31'd0, hit_valid}, 32'd1);
    check_val("lk13_hit", {31'd0, hit}, 32'd1);
    check_val("lk13_sel", {29'd0, hit_sel}, 32'd3);
    step();
    check_val("hv_pulse", {31'd0, hit_valid}, 32'd0);
    check_val("sel_hold", {29'd0, hit_sel}, 32'd3);
    do_lookup(8'h99, 1'b0);
    check_val("lk99_hv", {31'd0, hit_valid}, 32'd1);
    check_val("lk99_hit", {31'd0, hit}, 32'd0);
    check_val("lk99_sel", {29'd0, hit_sel}, 32'd0);

    // round-robin replacement from entry 0
    do_insert(8'h20);
    check_val("ev20_v", {31'd0, evict_valid}, 32'd1);
    check_val("ev20_tag", {24'd0, evict_tag}, 32'h10);
    do_insert(8'h21);
    check_val("ev21_v", {31'd0, evict_valid}, 32'd1);
    check_val("ev21_tag", {24'd0, evict_tag}, 32'h11);
    step();
    check_val("ev_pulse", {31'd0, evict_valid}, 32'd0);
    check_val("ev_tag_hold", {24'd0, evict_tag}, 32'h11);

    // take entry 5 while inserting 0x30 at rr_ptr=2
    lookup_valid = 1'b1; lookup_tag = 8'h15; lookup_take = 1'b1;
    insert_valid = 1'b1; insert_tag = 8'h30;
    step();
    idle();
    check_val("tk_hit", {31'd0, hit}, 32'd1);
    check_val("tk_sel", {29'd0, hit_sel}, 32'd5);
    check_val("tk_ev_v", {31'd0, evict_valid}, 32'd1);
    check_val("tk_ev_tag", {24'd0, evict_tag}, 32'h12);
    check_val("tk_count", {28'd0, count}, 32'd7);
    check_val("tk_full", {31'd0, full}, 32'd0);
    do_lookup(8'h15, 1'b0);
    check_val("tk_gone", {31'd0, hit}, 32'd0);
    do_lookup(8'h30, 1'b0);
    check_val("lk30_sel", {29'd0, hit_sel}, 32'd2);

    // free slot 5 reused before replacement
    do_insert(8'h40);
    check_val("in40_no_ev", {31'd0, evict_valid}, 32'd0);
    check_val("in40_count", {28'd0, count}, 32'd8);
    do_lookup(8'h40, 1'b0);
    check_val("lk40_sel", {29'd0, hit_sel}, 32'd5);

    // duplicate insert is a no-op
    do_insert(8'h20);
    check_val("dup_no_ev", {31'd0, evict_valid}, 32'd0);
    check_val("dup_count", {28'd0, count}, 32'd8);

    // take at rr_ptr=3 with same-cycle insert: insert wins
    lookup_valid = 1'b1; lookup_tag = 8'h13; lookup_take = 1'b1;
    insert_valid = 1'b1; insert_tag = 8'h50;
    step();
    idle();
    check_val("tkrr_sel", {29'd0, hit_sel}, 32'd3);
    check_val("tkrr_ev_tag", {24'd0, evict_tag}, 32'h13);
    check_val("tkrr_count", {28'd0, count}, 32'd8);
    do_lookup(8'h50, 1'b0);
    check_val("lk50_hit", {31'd0, hit}, 32'd1);
    check_val("lk50_sel", {29'd0, hit_sel}, 32'd3);

    // nine evictions from rr_ptr=4: wraps 7->0 and returns to 4
    for (int i = 0; i < 9; i++) begin
      do_insert(8'h60 + 8'(i));
      check_val("rr_ev_v", {31'd0, evict_valid}, 32'd1);
      check_val("rr_ev_tag", {24'd0, evict_tag}, {24'd0, exp_ev[i]});
    end

    // strobes low: payload ignored
    lookup_valid = 1'b0; lookup_tag = 8'h61; lookup_take = 1'b1;
    insert_valid = 1'b0; insert_tag = 8'hAA;
    step();
    idle();
    check_val("ign_hv", {31'd0, hit_valid}, 32'd0);
    check_val("ign_count", {28'd0, count}, 32'd8);
    do_lookup(8'h61, 1'b0);
    check_val("ign_kept", {31'd0, hit}, 32'd1);
    check_val("ign_sel", {29'd0, hit_sel}, 32'd5);

    // reset mid-lookup
    lookup_valid = 1'b1; lookup_tag = 8'h61; lookup_take = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_val("arst_count", {28'd0, count}, 32'd0);
    check_val("arst_full", {31'd0, full}, 32'd0);
    step();
    check_val("arst_hv", {31'd0, hit_valid}, 32'd0);
    reset = 1'b0;
    idle();
    step();
    check_val("post_rst_hv", {31'd0, hit_valid}, 32'd0);
    do_lookup(8'h10, 1'b0);
    check_val("post_rst_lk_hv", {31'd0, hit_valid}, 32'd1);
    check_val("post_rst_lk_hit", {31'd0, hit}, 32'd0);
    check_val("post_rst_count", {28'd0, count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", tb_checks, tb_errors);
    $finish;
  end

endmodule
